// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment loopback receiver: segment patterns and FSM states.
package seg_pkg;

  // Positive-logic segment patterns, bit0=a .. bit6=g; entry i decodes to nibble i.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {SEEK = 1'b0, COLLECT = 1'b1} rx_state_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational reverse lookup of a positive-logic segment pattern to a hex nibble.
module seven_seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic [3:0] nibble_out,
  output logic       blank_out,
  output logic       bad_out
);

  always_comb begin
    nibble_out = '0;
    blank_out  = (seg_in == SEG_BLANK);
    bad_out    = !blank_out;
    for (int i = 0; i < 16; i++) begin
      if (seg_in == SEG_HEX[i]) begin
        nibble_out = 4'(i);
        bad_out    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_seg_rx.sv
// Loopback monitor for the multiplexed 7-segment bus: samples settled digits, decodes them
// and publishes a complete frame once every digit has been seen since the last digit-0 capture.
module seven_seg_rx
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [6:0]              cat_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] val_out,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic [NUM_DIGITS-1:0]   bad_out,
  output logic                    valid_out,
  output logic                    an_err_out,
  output logic                    timeout_out
);

  localparam int W  = NUM_DIGITS + 7;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [W-1:0]                  s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic [SW-1:0]                 set_q, set_d;
  logic [TW-1:0]                 tmo_q, tmo_d;
  rx_state_t                     st_q, st_d;
  logic [NUM_DIGITS-1:0]         mask_q, mask_d;
  logic [NUM_DIGITS-1:0][3:0]    sh_val_q, sh_val_d, val_q, val_d;
  logic [NUM_DIGITS-1:0]         sh_blank_q, sh_blank_d, blank_q, blank_d;
  logic [NUM_DIGITS-1:0]         sh_bad_q, sh_bad_d, bad_q, bad_d;
  logic                          done_q, done_d, valid_q, valid_d;
  logic                          an_err_q, an_err_d, tmo_p_q, tmo_p_d;

  logic [NUM_DIGITS-1:0] an_act;
  logic [KW-1:0]         k;
  logic                  stable, sample, cap, wr;
  logic [3:0]            dec_nib;
  logic                  dec_blank, dec_bad;

  seven_seg_decode u_dec (
    .seg_in     (~s2_q[6:0]),
    .nibble_out (dec_nib),
    .blank_out  (dec_blank),
    .bad_out    (dec_bad)
  );

  always_comb begin
    s1_d   = {an_in, cat_in};
    s2_d   = s1_q;
    prev_d = s2_q;
    stable = (s2_q == prev_q);
    // Saturate one past the fire point so a long dwell fires exactly once.
    set_d  = !stable ? '0 : (set_q == SW'(SETTLE_CYCLES)) ? set_q : set_q + 1'b1;
    sample = stable && (set_q == SW'(SETTLE_CYCLES - 1));
    an_act = ~s2_q[W-1:7];
    cap    = sample && $onehot(an_act);
    an_err_d = sample && (an_act != '0) && !$onehot(an_act);
    k = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (an_act[i]) k = KW'(i);

    st_d       = st_q;
    mask_d     = mask_q;
    sh_val_d   = sh_val_q;
    sh_blank_d = sh_blank_q;
    sh_bad_d   = sh_bad_q;
    tmo_d      = '0;
    tmo_p_d    = 1'b0;
    done_d     = 1'b0;
    wr         = 1'b0;
    valid_d    = done_q;
    val_d      = done_q ? sh_val_q   : val_q;
    blank_d    = done_q ? sh_blank_q : blank_q;
    bad_d      = done_q ? sh_bad_q   : bad_q;

    case (st_q)
      SEEK: if (cap && k == '0) begin
        wr     = 1'b1;
        mask_d = '0;
        st_d   = COLLECT;
      end
      COLLECT: begin
        if (cap) wr = 1'b1;
        else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          mask_d  = '0;
          tmo_p_d = 1'b1;
          st_d    = SEEK;
        end else tmo_d = tmo_q + 1'b1;
      end
      default: st_d = SEEK;
    endcase

    if (wr) begin
      mask_d[k]     = 1'b1;
      sh_val_d[k]   = dec_nib;
      sh_blank_d[k] = dec_blank;
      sh_bad_d[k]   = dec_bad;
      if (&mask_d) begin
        done_d = 1'b1;
        mask_d = '0;
        st_d   = SEEK;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_q <= '0;  s2_q <= '0;  prev_q <= '0;
      set_q <= '0; tmo_q <= '0; st_q <= SEEK; mask_q <= '0;
      sh_val_q <= '0; sh_blank_q <= '0; sh_bad_q <= '0;
      val_q <= '0; blank_q <= '0; bad_q <= '0;
      done_q <= 1'b0; valid_q <= 1'b0; an_err_q <= 1'b0; tmo_p_q <= 1'b0;
    end else begin
      s1_q <= s1_d;  s2_q <= s2_d;  prev_q <= prev_d;
      set_q <= set_d; tmo_q <= tmo_d; st_q <= st_d; mask_q <= mask_d;
      sh_val_q <= sh_val_d; sh_blank_q <= sh_blank_d; sh_bad_q <= sh_bad_d;
      val_q <= val_d; blank_q <= blank_d; bad_q <= bad_d;
      done_q <= done_d; valid_q <= valid_d; an_err_q <= an_err_d; tmo_p_q <= tmo_p_d;
    end
  end

  assign val_out     = val_q;
  assign blank_out   = blank_q;
  assign bad_out     = bad_q;
  assign valid_out   = valid_q;
  assign an_err_out  = an_err_q;
  assign timeout_out = tmo_p_q;

endmodule

// File: tb/tb_seven_seg_rx.sv
// Directed bench for seven_seg_rx: scans digit patterns over the bus and checks decoded frames and pulses.
module tb_seven_seg_rx;

  localparam int ND = 8;
  localparam int ST = 16;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [6:0]      cat_in = 7'h7F;
  logic [ND-1:0]   an_in = '1;
  logic [4*ND-1:0] val_out;
  logic [ND-1:0]   blank_out, bad_out;
  logic            valid_out, an_err_out, timeout_out;

  int checks = 0, errors = 0;
  int valid_cnt = 0, err_cnt = 0, tmo_cnt = 0;
  int v0, e0, t0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_rx #(.NUM_DIGITS(ND), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk), .rst_in(rst), .cat_in(cat_in), .an_in(an_in),
    .val_out(val_out), .blank_out(blank_out), .bad_out(bad_out),
    .valid_out(valid_out), .an_err_out(an_err_out), .timeout_out(timeout_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out)   valid_cnt++;
    if (an_err_out)  err_cnt++;
    if (timeout_out) tmo_cnt++;
  end

  task automatic show(input int d, input logic [6:0] segs, input int n);
    logic [ND-1:0] one;
    one    = ND'(1) << d;
    an_in  = ~one;
    cat_in = ~segs;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    an_in  = '1;
    cat_in = 7'h7F;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    v0 = valid_cnt; e0 = err_cnt; t0 = tmo_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (val_out !== '0)    begin errors++; $display("FAIL reset_val: got %h want 0", val_out); end
    checks++; if (blank_out !== '0)  begin errors++; $display("FAIL reset_blank: got %h want 0", blank_out); end
    checks++; if (bad_out !== '0)    begin errors++; $display("FAIL reset_bad: got %h want 0", bad_out); end
    checks++; if ({valid_out, an_err_out, timeout_out} !== 3'b000)
      begin errors++; $display("FAIL reset_pulses: got %b want 000", {valid_out, an_err_out, timeout_out}); end
    rst = 1'b0;
    gap(5);
  endtask

  task automatic test_scan();
    snap();
    for (int d = 0; d < ND; d++) show(d, hex_tab[d], ST + 4);
    gap(30);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL scan_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (val_out !== 32'h7654_3210) begin errors++; $display("FAIL scan_val: got %h want 76543210", val_out); end
    checks++; if (blank_out !== 8'h00 || bad_out !== 8'h00)
      begin errors++; $display("FAIL scan_flags: got blank %h bad %h want 00 00", blank_out, bad_out); end
    checks++; if (err_cnt - e0 !== 0 || tmo_cnt - t0 !== 0)
      begin errors++; $display("FAIL scan_noerr: got an_err %0d timeout %0d want 0 0", err_cnt - e0, tmo_cnt - t0); end
  endtask

  task automatic test_special();
    logic [6:0] p;
    snap();
    for (int d = 0; d < ND; d++) begin
      p = (d == 3) ? 7'h77 : (d == 5) ? 7'h00 : (d == 6) ? 7'h55 : 7'h3F;
      show(d, p, ST + 4);
    end
    gap(30);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL special_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (val_out !== 32'h0000_A000) begin errors++; $display("FAIL special_val: got %h want 0000a000", val_out); end
    checks++; if (blank_out !== 8'h20) begin errors++; $display("FAIL special_blank: got %h want 20", blank_out); end
    checks++; if (bad_out !== 8'h40) begin errors++; $display("FAIL special_bad: got %h want 40", bad_out); end
  endtask

  task automatic test_fast();
    snap();
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < ND; d++) show(d, hex_tab[d], ST - 2);
    gap(20);
    checks++; if (valid_cnt - v0 !== 0 || tmo_cnt - t0 !== 0)
      begin errors++; $display("FAIL fast_idle: got valid %0d timeout %0d want 0 0", valid_cnt - v0, tmo_cnt - t0); end
    checks++; if (val_out !== 32'h0000_A000) begin errors++; $display("FAIL fast_hold: got %h want 0000a000", val_out); end
    snap();
    show(0, hex_tab[0], ST + 4);
    for (int r = 0; r < 2; r++)
      for (int d = 1; d < ND; d++) show(d, hex_tab[d], ST - 2);
    gap(20);
    checks++; if (tmo_cnt - t0 !== 1 || valid_cnt - v0 !== 0)
      begin errors++; $display("FAIL fast_timeout: got timeout %0d valid %0d want 1 0", tmo_cnt - t0, valid_cnt - v0); end
  endtask

  task automatic test_an_err();
    snap();
    an_in = 8'b1111_0011; cat_in = ~7'h3F;
    repeat (40) @(posedge clk); #1;
    cat_in = ~7'h06;
    repeat (40) @(posedge clk); #1;
    gap(10);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL an_err_seek: got %0d want 2", err_cnt - e0); end
    snap();
    for (int d = 0; d < 4; d++) show(d, hex_tab[d], ST + 4);
    an_in = 8'b1111_0011; cat_in = ~7'h3F;
    repeat (25) @(posedge clk); #1;
    for (int d = 4; d < ND; d++) show(d, hex_tab[d], ST + 4);
    gap(30);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL an_err_collect: got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 1 || tmo_cnt - t0 !== 0)
      begin errors++; $display("FAIL an_err_frame: got valid %0d timeout %0d want 1 0", valid_cnt - v0, tmo_cnt - t0); end
    checks++; if (val_out !== 32'h7654_3210) begin errors++; $display("FAIL an_err_val: got %h want 76543210", val_out); end
  endtask

  task automatic test_timeout();
    snap();
    for (int d = 0; d < 4; d++) show(d, hex_tab[8 + d], ST + 4);
    gap(100);
    checks++; if (tmo_cnt - t0 !== 1 || valid_cnt - v0 !== 0)
      begin errors++; $display("FAIL timeout_pulse: got timeout %0d valid %0d want 1 0", tmo_cnt - t0, valid_cnt - v0); end
    snap();
    for (int d = 0; d < ND; d++) show(d, hex_tab[15 - d], ST + 4);
    gap(30);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL timeout_rescan: got %0d want 1", valid_cnt - v0); end
    checks++; if (val_out !== 32'h89AB_CDEF) begin errors++; $display("FAIL timeout_val: got %h want 89abcdef", val_out); end
  endtask

  task automatic test_rst_mid();
    snap();
    for (int d = 0; d < 5; d++) show(d, hex_tab[d], ST + 4);
    an_in = ~(ND'(1) << 5); cat_in = ~hex_tab[5];
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (val_out !== '0 || blank_out !== '0 || bad_out !== '0)
      begin errors++; $display("FAIL rst_mid_outputs: got val %h blank %h bad %h want 0", val_out, blank_out, bad_out); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    gap(10);
    snap();
    for (int d = 5; d < ND; d++) show(d, hex_tab[d], ST + 4);
    gap(30);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL rst_mid_partial: got %0d want 0", valid_cnt - v0); end
    for (int d = 0; d < ND; d++) show(d, hex_tab[d], ST + 4);
    gap(30);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL rst_mid_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (val_out !== 32'h7654_3210) begin errors++; $display("FAIL rst_mid_val: got %h want 76543210", val_out); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_special();
    test_fast();
    test_an_err();
    test_timeout();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
